// File: rtl/irq_pkg.sv
// irq_pkg: shared constants for the interrupt controller.
//   Register word offsets inside the 16-byte window, default window base,
//   and the data-bus width.
package irq_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hFFFF_FF00;

    localparam logic [3:0] OFF_PENDING = 4'h0;
    localparam logic [3:0] OFF_MASK    = 4'h4;
    localparam logic [3:0] OFF_ACTIVE  = 4'h8;
    localparam logic [3:0] OFF_OVERRUN = 4'hC;

endpackage : irq_pkg

// File: rtl/irq_sync_edge.sv
// irq_sync_edge: multi-flop synchroniser plus one history flop per bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   async_i    : raw asynchronous inputs
//   rise_c     : one-cycle rising-edge pulse per bit (combinational from flops)
module irq_sync_edge #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] rise_c
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] hist_q;
    logic [WIDTH-1:0] hist_d;

    // Shift chain: stage 0 samples the raw input, history trails the last stage.
    always_comb begin
        sync_d[0] = async_i;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            hist_q <= '0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            hist_q <= hist_d;
        end
    end

    assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule : irq_sync_edge

// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt controller in front of the core's interrupt inputs.
//   clk, reset : clock, asynchronous active-low reset
//   irq_in     : raw asynchronous interrupt pulses
//   memwrite, dataadr, writedata : snooped core store bus
//   readdata   : combinational register read data (0 outside the window)
//   hit        : dataadr inside the 16-byte register window
//   irq_out    : registered PENDING & MASK
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned NUM_IRQ     = 8,
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               memwrite,
    input  logic [DATA_W-1:0]  dataadr,
    input  logic [DATA_W-1:0]  writedata,
    output logic [DATA_W-1:0]  readdata,
    output logic               hit,
    output logic [NUM_IRQ-1:0] irq_out
);

    logic [NUM_IRQ-1:0] rise_c;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] overrun_q, overrun_d;
    logic [NUM_IRQ-1:0] irq_out_q, irq_out_d;
    logic [NUM_IRQ-1:0] pend_clr_c, ovr_clr_c, wdata_c, active_c;
    logic [3:0]         off_c;
    logic               unused_c;

    irq_sync_edge #(
        .WIDTH      (NUM_IRQ),
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .rst_n  (reset),
        .async_i(irq_in),
        .rise_c (rise_c)
    );

    // Byte lanes inside a word are ignored; only the word offset selects.
    assign hit      = (dataadr[31:4] == BASE_ADDR[31:4]);
    assign off_c    = {dataadr[3:2], 2'b00};
    assign wdata_c  = writedata[NUM_IRQ-1:0];
    assign active_c = pending_q & mask_q;
    assign unused_c = ^{dataadr[1:0], writedata};

    // Register updates: a fresh edge always wins over a same-cycle W1C.
    always_comb begin
        pend_clr_c = '0;
        ovr_clr_c  = '0;
        mask_d     = mask_q;
        if (memwrite && hit) begin
            case (off_c)
                OFF_PENDING: pend_clr_c = wdata_c;
                OFF_MASK:    mask_d     = wdata_c;
                OFF_OVERRUN: ovr_clr_c  = wdata_c;
                default:     ;
            endcase
        end
        pending_d = (pending_q & ~pend_clr_c) | rise_c;
        // An edge that collides with a clear of its own pending bit is a
        // re-arm, not a lost interrupt, so it does not count as overrun.
        overrun_d = (overrun_q & ~ovr_clr_c) | (rise_c & pending_q & ~pend_clr_c);
        irq_out_d = pending_q & mask_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
            mask_q    <= '1;
            overrun_q <= '0;
            irq_out_q <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            overrun_q <= overrun_d;
            irq_out_q <= irq_out_d;
        end
    end

    assign irq_out = irq_out_q;

    // Read mux, zero-extended to the bus width.
    always_comb begin
        readdata = '0;
        if (hit) begin
            case (off_c)
                OFF_PENDING: readdata = DATA_W'(pending_q);
                OFF_MASK:    readdata = DATA_W'(mask_q);
                OFF_ACTIVE:  readdata = DATA_W'(active_c);
                OFF_OVERRUN: readdata = DATA_W'(overrun_q);
                default:     readdata = '0;
            endcase
        end
    end

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed self-checking bench for irq_ctrl.
module tb_irq_ctrl;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  irq_in;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        hit;
    logic [7:0]  irq_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .NUM_IRQ    (8),
        .BASE_ADDR  (BASE),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .memwrite (memwrite),
        .dataadr  (dataadr),
        .writedata(writedata),
        .readdata (readdata),
        .hit      (hit),
        .irq_out  (irq_out)
    );

    task automatic rd(input logic [31:0] adr, output logic [31:0] v);
        dataadr = adr;
        #1;
        v = readdata;
    endtask

    // Store lands on the next rising edge; returns 1 ns after it.
    task automatic wr(input logic [31:0] adr, input logic [31:0] d);
        @(negedge clk);
        memwrite  = 1'b1;
        dataadr   = adr;
        writedata = d;
        @(posedge clk);
        #1;
        memwrite  = 1'b0;
    endtask

    // One-clock-wide pulse from negedge to negedge.
    task automatic pulse(input int b);
        @(negedge clk);
        irq_in[b] = 1'b1;
        @(negedge clk);
        irq_in[b] = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0; irq_in = '0; memwrite = 1'b0; dataadr = '0; writedata = '0;
        #15;
        #2 reset = 1'b1;
        @(negedge clk);
        checks++; if (irq_out !== 8'h00) begin errors++; $display("FAIL rst_irq_out got %h exp %h", irq_out, 8'h00); end
        rd(BASE + 32'h4, v);
        checks++; if (v !== 32'hFF) begin errors++; $display("FAIL rst_mask got %h exp %h", v, 32'hFF); end
        rd(BASE + 32'h0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_pending got %h exp %h", v, 32'h0); end
        rd(BASE + 32'hC, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL rst_overrun got %h exp %h", v, 32'h0); end
    endtask

    task automatic test_single_pulse();
        logic [31:0] v;
        @(negedge clk); irq_in[1] = 1'b1;
        @(posedge clk);                       // edge N
        @(negedge clk); irq_in[1] = 1'b0;
        @(posedge clk);                       // N+1
        @(negedge clk); rd(BASE, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL lat_pend_n1 got %h exp %h", v, 32'h0); end
        @(posedge clk);                       // N+2
        @(negedge clk); rd(BASE, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL lat_pend_n2 got %h exp %h", v, 32'h2); end
        checks++; if (irq_out !== 8'h00) begin errors++; $display("FAIL lat_out_n2 got %h exp %h", irq_out, 8'h00); end
        @(posedge clk);                       // N+3
        @(negedge clk);
        checks++; if (irq_out !== 8'h02) begin errors++; $display("FAIL lat_out_n3 got %h exp %h", irq_out, 8'h02); end
        wr(BASE, 32'h2);                      // write edge W
        checks++; if (irq_out !== 8'h02) begin errors++; $display("FAIL clr_out_w got %h exp %h", irq_out, 8'h02); end
        rd(BASE, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL clr_pend got %h exp %h", v, 32'h0); end
        @(posedge clk); #1;                   // W+1
        checks++; if (irq_out !== 8'h00) begin errors++; $display("FAIL clr_out_w1 got %h exp %h", irq_out, 8'h00); end
    endtask

    task automatic test_mask();
        logic [31:0] v;
        wr(BASE + 32'h4, 32'h0);
        pulse(0);
        repeat (4) @(negedge clk);
        rd(BASE, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL mask_pend got %h exp %h", v, 32'h1); end
        rd(BASE + 32'h8, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mask_active got %h exp %h", v, 32'h0); end
        checks++; if (irq_out !== 8'h00) begin errors++; $display("FAIL mask_out got %h exp %h", irq_out, 8'h00); end
        wr(BASE + 32'h4, 32'h1);
        checks++; if (irq_out !== 8'h00) begin errors++; $display("FAIL unmask_out_w got %h exp %h", irq_out, 8'h00); end
        @(posedge clk); #1;
        checks++; if (irq_out !== 8'h01) begin errors++; $display("FAIL unmask_out_w1 got %h exp %h", irq_out, 8'h01); end
        rd(BASE + 32'h8, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL unmask_active got %h exp %h", v, 32'h1); end
        wr(BASE, 32'h1);
        // Bits above NUM_IRQ read back 0; byte offset does not change the selected word.
        wr(BASE + 32'h4, 32'hFFFF_FF0F);
        @(negedge clk); rd(BASE + 32'h5, v);
        checks++; if (v !== 32'h0F) begin errors++; $display("FAIL mask_width got %h exp %h", v, 32'h0F); end
        wr(BASE + 32'h4, 32'hFF);
    endtask

    task automatic test_overrun();
        logic [31:0] v;
        pulse(1);
        repeat (7) @(negedge clk);
        pulse(1);                             // starts 90 ns after the first
        repeat (4) @(negedge clk);
        rd(BASE, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL ovr_pend got %h exp %h", v, 32'h2); end
        rd(BASE + 32'hC, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL ovr_set got %h exp %h", v, 32'h2); end
        wr(BASE + 32'hC, 32'h2);
        @(negedge clk); rd(BASE + 32'hC, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL ovr_clr got %h exp %h", v, 32'h0); end
        rd(BASE, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL ovr_pend_kept got %h exp %h", v, 32'h2); end
        wr(BASE, 32'h2);
    endtask

    task automatic test_collision();
        logic [31:0] v;
        pulse(1);
        repeat (3) @(negedge clk);
        rd(BASE, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL col_pre_pend got %h exp %h", v, 32'h2); end
        @(negedge clk); irq_in[1] = 1'b1;
        @(posedge clk);                       // N
        @(negedge clk); irq_in[1] = 1'b0;
        @(posedge clk);                       // N+1: edge visible
        @(negedge clk);
        memwrite = 1'b1; dataadr = BASE; writedata = 32'h2;
        @(posedge clk);                       // N+2: edge and W1C together
        #1 memwrite = 1'b0;
        rd(BASE, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL col_pend got %h exp %h", v, 32'h2); end
        rd(BASE + 32'hC, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL col_overrun got %h exp %h", v, 32'h0); end
        @(posedge clk); #1;
        checks++; if (irq_out !== 8'h02) begin errors++; $display("FAIL col_out got %h exp %h", irq_out, 8'h02); end
        wr(BASE, 32'h2);
    endtask

    task automatic test_level();
        logic [31:0] v;
        @(negedge clk); irq_in[3] = 1'b1;
        repeat (6) @(negedge clk);
        wr(BASE, 32'h8);                      // clear while the level is still high
        repeat (4) @(negedge clk);
        rd(BASE, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL level_pend got %h exp %h", v, 32'h0); end
        rd(BASE + 32'hC, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL level_overrun got %h exp %h", v, 32'h0); end
        irq_in[3] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_decode();
        logic [31:0] v;
        pulse(2);
        repeat (3) @(negedge clk);
        rd(BASE, v);
        checks++; if (v !== 32'h4) begin errors++; $display("FAIL dec_pre_pend got %h exp %h", v, 32'h4); end
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL dec_hit_in got %b exp %b", hit, 1'b1); end
        rd(BASE + 32'h10, v);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL dec_hit_out got %b exp %b", hit, 1'b0); end
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL dec_rdata_out got %h exp %h", v, 32'h0); end
        wr(BASE + 32'h10, 32'hFFFF_FFFF);
        wr(32'h14, 32'h0);
        @(negedge clk); rd(32'h14, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL dec_rdata_14 got %h exp %h", v, 32'h0); end
        rd(BASE, v);
        checks++; if (v !== 32'h4) begin errors++; $display("FAIL dec_pend_kept got %h exp %h", v, 32'h4); end
        rd(BASE + 32'h4, v);
        checks++; if (v !== 32'hFF) begin errors++; $display("FAIL dec_mask_kept got %h exp %h", v, 32'hFF); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        @(negedge clk);
        checks++; if (irq_out !== 8'h04) begin errors++; $display("FAIL mid_pre_out got %h exp %h", irq_out, 8'h04); end
        #2 reset = 1'b0;
        #1;
        checks++; if (irq_out !== 8'h00) begin errors++; $display("FAIL mid_async_out got %h exp %h", irq_out, 8'h00); end
        @(negedge clk); reset = 1'b1;
        @(negedge clk); rd(BASE, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_pend got %h exp %h", v, 32'h0); end
        rd(BASE + 32'h4, v);
        checks++; if (v !== 32'hFF) begin errors++; $display("FAIL mid_mask got %h exp %h", v, 32'hFF); end
        checks++; if (irq_out !== 8'h00) begin errors++; $display("FAIL mid_out got %h exp %h", irq_out, 8'h00); end
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_mask();
        test_overrun();
        test_collision();
        test_level();
        test_decode();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_irq_ctrl
